// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: stalls, flushes, bubbles, and operand forwarding.
// Defining HAZ_PERF_CNT_EN adds the stall_cnt performance counter output.
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rs_a_deco,
  input  logic [3:0] rs_b_deco,
  input  logic       use_a,
  input  logic       use_b,
  input  logic [3:0] rd_exe,
  input  logic       we_exe,
  input  logic       load_exe,
  input  logic [3:0] rd_mem,
  input  logic       we_mem,
  input  logic [3:0] rd_wb,
  input  logic       we_wb,
  input  logic       branch_exe,
  input  logic       mem_busy,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       stall_de,
  output logic       stall_em,
  output logic       flush_fd,
  output logic       bubble_de,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FLUSH} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       load_use;

  assign load_use = we_exe & load_exe &
                    ((use_a & (rd_exe == rs_a_deco)) | (use_b & (rd_exe == rs_b_deco)));

  // A load's data is not available in EXE, so it is never forwarded from there.
  function automatic logic [1:0] fwd_sel(input logic [3:0] rs, input logic used);
    if (!used)                                   return 2'b00;
    else if (we_exe && !load_exe && rd_exe == rs) return 2'b01;
    else if (we_mem && rd_mem == rs)              return 2'b10;
    else if (we_wb && rd_wb == rs)                return 2'b11;
    else                                          return 2'b00;
  endfunction

  assign fwd_a       = fwd_sel(rs_a_deco, use_a);
  assign fwd_b       = fwd_sel(rs_b_deco, use_b);
  assign mem_timeout = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_busy)        state_d = S_WAIT;
        else if (branch_exe) state_d = S_FLUSH;
      end
      S_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = '0;
          state_d    = branch_exe ? S_FLUSH : S_RUN;
        end
      end
      S_FLUSH: begin
        if (!mem_busy) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
    timeout_d = timeout_q | (wait_cnt_d == 8'hFF);
  end

  // Reset is folded in combinationally so the controls drop the moment rst_n falls.
  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    stall_de  = 1'b0;
    stall_em  = 1'b0;
    flush_fd  = 1'b0;
    bubble_de = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        stall_pc = 1'b1;
        stall_fd = 1'b1;
        stall_de = 1'b1;
        stall_em = 1'b1;
      end else if (state_q == S_FLUSH) begin
        flush_fd = 1'b1;
      end else if (branch_exe) begin
        flush_fd  = 1'b1;
        bubble_de = 1'b1;
      end else if (load_use) begin
        stall_pc  = 1'b1;
        stall_fd  = 1'b1;
        bubble_de = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stall_cnt_q <= '0;
    else if (stall_pc && stall_cnt_q != '1)  stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rs_a_deco, rs_b_deco, rd_exe, rd_mem, rd_wb;
  logic       use_a, use_b, we_exe, load_exe, we_mem, we_wb, branch_exe, mem_busy;
  logic       stall_pc, stall_fd, stall_de, stall_em, flush_fd, bubble_de, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt;
  int          m_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: a flush cycle is owed, memory wait in progress, cycles waited.
  bit m_flush_owed;
  bit m_waiting;
  int m_wait_cycles;
  bit m_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_a_deco  (rs_a_deco),
    .rs_b_deco  (rs_b_deco),
    .use_a      (use_a),
    .use_b      (use_b),
    .rd_exe     (rd_exe),
    .we_exe     (we_exe),
    .load_exe   (load_exe),
    .rd_mem     (rd_mem),
    .we_mem     (we_mem),
    .rd_wb      (rd_wb),
    .we_wb      (we_wb),
    .branch_exe (branch_exe),
    .mem_busy   (mem_busy),
    .stall_pc   (stall_pc),
    .stall_fd   (stall_fd),
    .stall_de   (stall_de),
    .stall_em   (stall_em),
    .flush_fd   (flush_fd),
    .bubble_de  (bubble_de),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_owed  = 0;
    m_waiting     = 0;
    m_wait_cycles = 0;
    m_timeout     = 0;
`ifdef HAZ_PERF_CNT_EN
    m_stall_cnt   = 0;
`endif
  endtask

  function automatic logic [1:0] exp_fwd(input logic [3:0] rs, input logic used);
    if (!used) return 2'd0;
    if (we_exe && !load_exe && rd_exe == rs) return 2'd1;
    if (we_mem && rd_mem == rs) return 2'd2;
    if (we_wb && rd_wb == rs) return 2'd3;
    return 2'd0;
  endfunction

  // Checks one cycle against the model with the current inputs, then advances a clock.
  task automatic step(input string tag);
    logic [5:0] exp_ctl, obs_ctl;
    bit         lu;
    #2;
    if (!rst_n) model_reset();
    lu = we_exe && load_exe && ((use_a && rd_exe == rs_a_deco) || (use_b && rd_exe == rs_b_deco));
    // {stall_pc, stall_fd, stall_de, stall_em, flush_fd, bubble_de}
    if (!rst_n)            exp_ctl = 6'b0000_00;
    else if (mem_busy)     exp_ctl = 6'b1111_00;
    else if (m_flush_owed) exp_ctl = 6'b0000_10;
    else if (branch_exe)   exp_ctl = 6'b0000_11;
    else if (lu)           exp_ctl = 6'b1100_01;
    else                   exp_ctl = 6'b0000_00;
    obs_ctl = {stall_pc, stall_fd, stall_de, stall_em, flush_fd, bubble_de};
    check({tag, ".ctl"}, 16'(obs_ctl), 16'(exp_ctl));
    check({tag, ".fwd_a"}, 16'(fwd_a), 16'(exp_fwd(rs_a_deco, use_a)));
    check({tag, ".fwd_b"}, 16'(fwd_b), 16'(exp_fwd(rs_b_deco, use_b)));
    check({tag, ".timeout"}, 16'(mem_timeout), 16'(m_timeout));
    check({tag, ".bub_vs_stall_de"}, 16'(bubble_de & stall_de), 16'd0);
`ifdef HAZ_PERF_CNT_EN
    check({tag, ".stall_cnt"}, stall_cnt, 16'(m_stall_cnt));
`endif
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
`ifdef HAZ_PERF_CNT_EN
      if (exp_ctl[5] && m_stall_cnt < 65535) m_stall_cnt++;
`endif
      if (mem_busy) begin
        if (!m_flush_owed) begin
          if (m_waiting && m_wait_cycles < 255) m_wait_cycles++;
          m_waiting = 1;
          if (m_wait_cycles >= 255) m_timeout = 1;
        end
      end else begin
        m_flush_owed  = m_flush_owed ? 1'b0 : branch_exe;
        m_waiting     = 0;
        m_wait_cycles = 0;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rs_a_deco = 0; rs_b_deco = 0; use_a = 0; use_b = 0;
    rd_exe = 0; we_exe = 0; load_exe = 0;
    rd_mem = 0; we_mem = 0; rd_wb = 0; we_wb = 0;
    branch_exe = 0; mem_busy = 0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst_n = 1'b0;
    mem_busy = 1; branch_exe = 1;
    step("reset_hold");
    idle_inputs();
    step("reset_idle");
    rst_n = 1'b1;
    step("run_idle");

    // Load-use on R3, then the hazard clears once the load leaves EXE.
    rd_exe = 3; we_exe = 1; load_exe = 1; rs_a_deco = 3; use_a = 1;
    step("loaduse");
    load_exe = 0; we_exe = 0;
    step("loaduse_after");
    // Load-use on R0 through operand B.
    rd_exe = 0; we_exe = 1; load_exe = 1; rs_b_deco = 0; use_b = 1; use_a = 0;
    step("loaduse_r0");
    idle_inputs();

    // Forwarding priority on operand B.
    rd_exe = 5; we_exe = 1; rd_mem = 5; we_mem = 1; rd_wb = 5; we_wb = 1;
    rs_b_deco = 5; use_b = 1;
    step("fwd_exe");
    we_exe = 0;
    step("fwd_mem");
    we_mem = 0;
    step("fwd_wb");
    use_b = 0;
    step("fwd_unused");
    idle_inputs();

    // Branch: two flush cycles, bubble only in the first.
    branch_exe = 1;
    step("br_run");
    branch_exe = 0;
    step("br_flush");
    step("br_done");

    // Branch then memory stall while flushing.
    branch_exe = 1;
    step("brm_run");
    branch_exe = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++) step("brm_busy");
    mem_busy = 0;
    step("brm_flush");
    step("brm_done");

    // Memory timeout: sticky flag after 255 WAIT cycles.
    mem_busy = 1;
    for (int i = 1; i <= 300; i++) begin
      step("to_busy");
      if (i == 255) check("to_not_yet", 16'(mem_timeout), 16'd0);
      if (i == 256) check("to_raised", 16'(mem_timeout), 16'd1);
    end
    mem_busy = 0;
    for (int i = 0; i < 4; i++) step("to_sticky");
    check("to_still_set", 16'(mem_timeout), 16'd1);

    // Reset in the middle of a memory wait.
    mem_busy = 1;
    for (int i = 0; i < 5; i++) step("rw_busy");
    rst_n = 1'b0;
    #1;
    check("rw_async_stall_pc", 16'(stall_pc), 16'd0);
    check("rw_async_timeout", 16'(mem_timeout), 16'd0);
    step("rw_reset");
    rst_n = 1'b1;
    mem_busy = 0;
    step("rw_resume");

    // Random traffic with narrow register ranges so matches are frequent.
    for (int i = 0; i < 600; i++) begin
      rs_a_deco  = 4'($urandom_range(0, 3));
      rs_b_deco  = 4'($urandom_range(0, 3));
      rd_exe     = 4'($urandom_range(0, 3));
      rd_mem     = 4'($urandom_range(0, 3));
      rd_wb      = 4'($urandom_range(0, 3));
      use_a      = 1'($urandom);
      use_b      = 1'($urandom);
      we_exe     = 1'($urandom);
      load_exe   = 1'($urandom);
      we_mem     = 1'($urandom);
      we_wb      = 1'($urandom);
      branch_exe = ($urandom_range(0, 5) == 0);
      mem_busy   = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
